// File: rtl/result_bypass_net_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | result_bypass_net_pkg                                                      |
// | Shared widths, stage-entry layout and latency clamp for the bypass network.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package result_bypass_net_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int ADDR_W_DEF = 7;
    localparam int DEPTH_DEF  = 7;
    localparam int LAT_W      = 3;

    // Layout of one pipe stage at the default widths; lanes mirror this shape.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic [LAT_W-1:0]      lat;
    } stage_entry_t;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat,
                                                   input int               depth);
        logic [LAT_W-1:0] r;
        r = lat;
        if (lat == '0)
            r = LAT_W'(1);
        else if (int'(lat) > depth)
            r = LAT_W'(depth);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_bypass_net_bypass_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bypass_lane                                                                |
// | One lane of result stages: free-running shift register with flush kill.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bypass_lane
    import result_bypass_net_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FLUSH_STAGES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_valid,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [DATA_W-1:0]             i_data,
    input  logic [LAT_W-1:0]              i_lat,
    output logic [DEPTH-1:0]              o_stg_valid,
    output logic [DEPTH-1:0]              o_nxt_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_stg_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]  o_stg_data,
    output logic [DEPTH-1:0][LAT_W-1:0]   o_stg_lat
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LAT_W-1:0]  lat;
    } entry_t;

    entry_t             r_stg [DEPTH];
    logic [DEPTH-1:0]   w_nxt_valid;

    // Flush kills whatever would land in the youngest FLUSH_STAGES slots.
    always_comb begin
        w_nxt_valid    = '0;
        w_nxt_valid[0] = i_valid & ~(i_flush && (FLUSH_STAGES > 0));
        for (int k = 1; k < DEPTH; k++)
            w_nxt_valid[k] = r_stg[k-1].valid & ~(i_flush && (k < FLUSH_STAGES));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                r_stg[k] <= '0;
        end else begin
            r_stg[0].valid <= w_nxt_valid[0];
            r_stg[0].addr  <= i_addr;
            r_stg[0].data  <= i_data;
            r_stg[0].lat   <= clamp_lat(i_lat, DEPTH);
            for (int k = 1; k < DEPTH; k++) begin
                r_stg[k].valid <= w_nxt_valid[k];
                r_stg[k].addr  <= r_stg[k-1].addr;
                r_stg[k].data  <= r_stg[k-1].data;
                r_stg[k].lat   <= r_stg[k-1].lat;
            end
        end
    end

    always_comb begin
        o_nxt_valid = w_nxt_valid;
        for (int k = 0; k < DEPTH; k++) begin
            o_stg_valid[k] = r_stg[k].valid;
            o_stg_addr[k]  = r_stg[k].addr;
            o_stg_data[k]  = r_stg[k].data;
            o_stg_lat[k]   = r_stg[k].lat;
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_bypass_net.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | result_bypass_net                                                          |
// | Multi-lane result pipe with operand forwarding, writeback and occupancy.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module result_bypass_net
    import result_bypass_net_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int RD_PORTS     = 3,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int FLUSH_STAGES = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [LANES-1:0]                        issue_valid,
    input  logic [LANES-1:0][ADDR_W-1:0]            issue_addr,
    input  logic [LANES-1:0][DATA_W-1:0]            issue_data,
    input  logic [LANES-1:0][LAT_W-1:0]             issue_lat,
    input  logic                                    flush,
    input  logic [LANES*RD_PORTS-1:0][ADDR_W-1:0]   rd_addr,
    input  logic [LANES*RD_PORTS-1:0][DATA_W-1:0]   rf_data,
    output logic [LANES*RD_PORTS-1:0][DATA_W-1:0]   fw_data,
    output logic [LANES*RD_PORTS-1:0]               fw_hit,
    output logic                                    fw_stall,
    output logic [LANES-1:0]                        wb_valid,
    output logic [LANES-1:0][ADDR_W-1:0]            wb_addr,
    output logic [LANES-1:0][DATA_W-1:0]            wb_data,
    output logic [$clog2(LANES*DEPTH+1)-1:0]        occupancy
);

    localparam int NP    = LANES * RD_PORTS;
    localparam int OCC_W = $clog2(LANES * DEPTH + 1);

    logic [LANES-1:0][DEPTH-1:0]              w_stg_valid;
    logic [LANES-1:0][DEPTH-1:0]              w_nxt_valid;
    logic [LANES-1:0][DEPTH-1:0][ADDR_W-1:0]  w_stg_addr;
    logic [LANES-1:0][DEPTH-1:0][DATA_W-1:0]  w_stg_data;
    logic [LANES-1:0][DEPTH-1:0][LAT_W-1:0]   w_stg_lat;
    logic [NP-1:0]                            w_found;
    logic [NP-1:0]                            w_rdy;
    logic [NP-1:0][DATA_W-1:0]                w_win_data;
    logic [OCC_W-1:0]                         w_occ_nxt;
    logic [OCC_W-1:0]                         r_occ;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bypass_lane #(
            .DEPTH        (DEPTH),
            .DATA_W       (DATA_W),
            .ADDR_W       (ADDR_W),
            .FLUSH_STAGES (FLUSH_STAGES)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (flush),
            .i_valid     (issue_valid[l]),
            .i_addr      (issue_addr[l]),
            .i_data      (issue_data[l]),
            .i_lat       (issue_lat[l]),
            .o_stg_valid (w_stg_valid[l]),
            .o_nxt_valid (w_nxt_valid[l]),
            .o_stg_addr  (w_stg_addr[l]),
            .o_stg_data  (w_stg_data[l]),
            .o_stg_lat   (w_stg_lat[l])
        );
    end

    // Scan oldest-to-youngest, low-to-high lane: the last match written wins.
    always_comb begin
        fw_stall   = 1'b0;
        w_found    = '0;
        w_rdy      = '0;
        w_win_data = '0;
        fw_hit     = '0;
        fw_data    = '0;
        for (int p = 0; p < NP; p++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (w_stg_valid[l][s] && (w_stg_addr[l][s] == rd_addr[p])) begin
                        w_found[p]    = 1'b1;
                        w_rdy[p]      = ((s + 1) >= int'(w_stg_lat[l][s]));
                        w_win_data[p] = w_stg_data[l][s];
                    end
                end
            end
            fw_hit[p]  = w_found[p] & w_rdy[p];
            fw_data[p] = fw_hit[p] ? w_win_data[p] : rf_data[p];
            fw_stall   = fw_stall | (w_found[p] & ~w_rdy[p]);
        end
    end

    // A higher lane writing the same register this cycle suppresses lower lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            wb_addr[l]  = w_stg_addr[l][DEPTH-1];
            wb_data[l]  = w_stg_data[l][DEPTH-1];
            wb_valid[l] = w_stg_valid[l][DEPTH-1];
            for (int m = l + 1; m < LANES; m++) begin
                if (w_stg_valid[m][DEPTH-1] &&
                    (w_stg_addr[m][DEPTH-1] == w_stg_addr[l][DEPTH-1]))
                    wb_valid[l] = 1'b0;
            end
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int l = 0; l < LANES; l++)
            for (int k = 0; k < DEPTH; k++)
                w_occ_nxt = w_occ_nxt + OCC_W'(w_nxt_valid[l][k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_occ <= '0;
        else
            r_occ <= w_occ_nxt;
    end

    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_result_bypass_net.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_result_bypass_net                                                       |
// | Directed scoreboard bench for result_bypass_net (DEPTH=4, FLUSH_STAGES=1). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_result_bypass_net;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int RDP   = 3;
    localparam int NP    = LANES * RDP;
    localparam int DW    = 128;
    localparam int AW    = 7;
    localparam int OCCW  = $clog2(LANES * DEPTH + 1);

    logic                       clk;
    logic                       rst;
    logic [LANES-1:0]           issue_valid;
    logic [LANES-1:0][AW-1:0]   issue_addr;
    logic [LANES-1:0][DW-1:0]   issue_data;
    logic [LANES-1:0][2:0]      issue_lat;
    logic                       flush;
    logic [NP-1:0][AW-1:0]      rd_addr;
    logic [NP-1:0][DW-1:0]      rf_data;
    logic [NP-1:0][DW-1:0]      fw_data;
    logic [NP-1:0]              fw_hit;
    logic                       fw_stall;
    logic [LANES-1:0]           wb_valid;
    logic [LANES-1:0][AW-1:0]   wb_addr;
    logic [LANES-1:0][DW-1:0]   wb_data;
    logic [OCCW-1:0]            occupancy;

    result_bypass_net #(
        .LANES(LANES), .DEPTH(DEPTH), .RD_PORTS(RDP),
        .DATA_W(DW), .ADDR_W(AW), .FLUSH_STAGES(1)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_data(issue_data), .issue_lat(issue_lat),
        .flush(flush), .rd_addr(rd_addr), .rf_data(rf_data),
        .fw_data(fw_data), .fw_hit(fw_hit), .fw_stall(fw_stall),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit             chk_fw;
        bit             chk_occ;
        int             port;
        logic           hit;
        logic           stall;
        logic [DW-1:0]  data;
        logic [OCCW-1:0] occ;
    } fw_exp_t;

    typedef struct {
        int             lane;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } wb_exp_t;

    fw_exp_t fw_q[$];
    wb_exp_t wb_q[$];
    fw_exp_t m_e;
    wb_exp_t m_w;
    int      chk_cnt;
    int      checks;
    int      failures;

    function automatic logic [DW-1:0] rf_val(input int p);
        return {4{32'hF00D_0000 + 32'(p)}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        issue_valid = '0;
        flush       = 1'b0;
        chk_cnt     = 0;
        for (int p = 0; p < NP; p++) rd_addr[p] = 7'h7F;
    endtask

    task automatic issue(input int l, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [2:0] lat, input bit exp_wb);
        wb_exp_t w;
        issue_valid[l] = 1'b1;
        issue_addr[l]  = a;
        issue_data[l]  = d;
        issue_lat[l]   = lat;
        if (exp_wb) begin
            w.lane = l; w.addr = a; w.data = d;
            wb_q.push_back(w);
        end
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic hit,
                      input logic stall, input logic [DW-1:0] d);
        fw_exp_t e;
        rd_addr[p] = a;
        e.chk_fw = 1'b1; e.chk_occ = 1'b0; e.port = p;
        e.hit = hit; e.stall = stall; e.data = d; e.occ = '0;
        fw_q.push_back(e);
        chk_cnt++;
    endtask

    task automatic occ_chk(input logic [OCCW-1:0] o);
        fw_exp_t e;
        e.chk_fw = 1'b0; e.chk_occ = 1'b1; e.port = 0;
        e.hit = 1'b0; e.stall = 1'b0; e.data = '0; e.occ = o;
        fw_q.push_back(e);
        chk_cnt++;
    endtask

    // Monitor: consumes expectations whenever the bench flags a read or the DUT writes back.
    always @(negedge clk) begin
        for (int i = 0; i < chk_cnt; i++) begin
            if (fw_q.size() == 0) begin
                check("fw_queue_underflow", 128'd1, 128'd0);
            end else begin
                m_e = fw_q.pop_front();
                if (m_e.chk_fw) begin
                    check("fw_hit",   128'(fw_hit[m_e.port]), 128'(m_e.hit));
                    check("fw_stall", 128'(fw_stall),         128'(m_e.stall));
                    check("fw_data",  fw_data[m_e.port],      m_e.data);
                end
                if (m_e.chk_occ)
                    check("occupancy", 128'(occupancy), 128'(m_e.occ));
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (wb_valid[l] !== 1'b0) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 128'(l + 1), 128'd0);
                end else begin
                    m_w = wb_q.pop_front();
                    check("wb_lane", 128'(l),          128'(m_w.lane));
                    check("wb_addr", 128'(wb_addr[l]), 128'(m_w.addr));
                    check("wb_data", wb_data[l],       m_w.data);
                end
            end
        end
    end

    initial begin
        checks = 0; failures = 0; chk_cnt = 0;
        rst = 1'b1; flush = 1'b0;
        issue_valid = '0; issue_addr = '0; issue_data = '0; issue_lat = '0;
        for (int p = 0; p < NP; p++) begin
            rd_addr[p] = 7'h7F;
            rf_data[p] = rf_val(p);
        end

        // Reset state
        tick();
        rd(0, 7'h7F, 1'b0, 1'b0, rf_val(0)); occ_chk(0);
        tick();

        // Latency-2 entry: stalls in stage 1, forwards from stage 2
        rst = 1'b0;
        issue(0, 7'd5, {16{8'hAA}}, 3'd2, 1'b1); tick();
        rd(0, 7'd5, 1'b0, 1'b1, rf_val(0)); occ_chk(1); tick();
        rd(0, 7'd5, 1'b1, 1'b0, {16{8'hAA}}); occ_chk(1); tick();
        tick();
        occ_chk(1); tick();
        occ_chk(0); tick();

        // Youngest match wins
        issue(0, 7'd9, {8{16'hA0A0}}, 3'd1, 1'b1); tick();
        issue(0, 7'd9, {8{16'hB0B0}}, 3'd1, 1'b1);
        rd(0, 7'd9, 1'b1, 1'b0, {8{16'hA0A0}}); tick();
        rd(0, 7'd9, 1'b1, 1'b0, {8{16'hB0B0}}); occ_chk(2); tick();
        repeat (3) tick();
        occ_chk(0); tick();

        // Same-stage tie and same-address writeback: lane 1 wins
        issue(0, 7'd3, 128'd1, 3'd1, 1'b0);
        issue(1, 7'd3, 128'd2, 3'd1, 1'b1); tick();
        rd(0, 7'd3, 1'b1, 1'b0, 128'd2); rd(4, 7'd3, 1'b1, 1'b0, 128'd2); occ_chk(2); tick();
        repeat (3) tick();
        occ_chk(0); tick();

        // Flush kills the issuing cycle only; older entry survives to writeback
        issue(0, 7'd4, {16{8'h44}}, 3'd1, 1'b1); tick();
        flush = 1'b1;
        issue(0, 7'd4, {16{8'h66}}, 3'd1, 1'b0);
        issue(1, 7'd8, {16{8'h88}}, 3'd1, 1'b0);
        rd(0, 7'd4, 1'b1, 1'b0, {16{8'h44}}); occ_chk(1); tick();
        rd(0, 7'd4, 1'b1, 1'b0, {16{8'h44}}); rd(1, 7'd8, 1'b0, 1'b0, rf_val(1)); occ_chk(1); tick();
        repeat (2) tick();
        occ_chk(0); tick();

        // Latency clamp: 0 -> ready at stage 1, 7 -> ready at stage DEPTH
        issue(0, 7'd10, {4{32'hC0DE_0010}}, 3'd0, 1'b1);
        issue(1, 7'd11, {4{32'hC0DE_0011}}, 3'd7, 1'b1); tick();
        rd(0, 7'd10, 1'b1, 1'b1, {4{32'hC0DE_0010}}); rd(3, 7'd11, 1'b0, 1'b1, rf_val(3)); tick();
        rd(3, 7'd11, 1'b0, 1'b1, rf_val(3)); tick();
        rd(3, 7'd11, 1'b0, 1'b1, rf_val(3)); tick();
        rd(3, 7'd11, 1'b1, 1'b0, {4{32'hC0DE_0011}}); rd(0, 7'd10, 1'b1, 1'b0, {4{32'hC0DE_0010}}); tick();
        occ_chk(0); tick();

        // Fill both lanes, then reset mid-stream: nothing may write back
        for (int c = 0; c < DEPTH; c++) begin
            issue(0, 7'(20 + c), 128'(c + 1),   3'd1, 1'b0);
            issue(1, 7'(30 + c), 128'(c + 101), 3'd1, 1'b0);
            if (c == DEPTH - 1) occ_chk(6);
            tick();
        end
        rst = 1'b1;
        rd(0, 7'd20, 1'b0, 1'b0, rf_val(0)); occ_chk(0); tick();
        rd(0, 7'd21, 1'b0, 1'b0, rf_val(0)); occ_chk(0); tick();
        rst = 1'b0;
        repeat (6) tick();
        occ_chk(0); tick();
        tick();

        check("wb_queue_drained", 128'(wb_q.size()), 128'd0);
        check("fw_queue_drained", 128'(fw_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_bypass_net.md
RESULT_BYPASS_NET -- requirements
Module: result_bypass_net

Interface
REQ-001 SHALL take parameter LANES, default 2: number of issue lanes (lane 0 = even pipe, lane 1 = odd pipe).
REQ-002 SHALL take parameter DEPTH, default 7: number of result stages per lane; stage DEPTH is the writeback stage.
REQ-003 SHALL take parameter RD_PORTS, default 3: operand read ports per lane (ra, rb, rc).
REQ-004 SHALL take parameter DATA_W, default 128: register data width.
REQ-005 SHALL take parameter ADDR_W, default 7: register address width.
REQ-006 SHALL take parameter FLUSH_STAGES, default 1: number of youngest stages killed by flush.
REQ-007 clock  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 issue_valid  in  LANES  result entry enters stage 1 this cycle.
REQ-010 issue_addr  in  LANES x ADDR_W  destination register (rt).
REQ-011 issue_data  in  LANES x DATA_W  result value.
REQ-012 issue_lat  in  LANES x 3  unit latency in cycles.
REQ-013 flush  in  1  branch-taken kill.
REQ-014 rd_addr  in  LANES*RD_PORTS x ADDR_W  operand addresses.
REQ-015 rf_data  in  LANES*RD_PORTS x DATA_W  register file read data.
REQ-016 fw_data  out  LANES*RD_PORTS x DATA_W  resolved operand value.
REQ-017 fw_hit  out  LANES*RD_PORTS  operand sourced from a pipe stage.
REQ-018 fw_stall  out  1  youngest match not yet ready.
REQ-019 wb_valid / wb_addr / wb_data  out  LANES / LANES x ADDR_W / LANES x DATA_W  register file write port.
REQ-020 occupancy  out  clog2(LANES*DEPTH+1)  count of valid entries in all stages.

Function
REQ-021 Each lane SHALL be a DEPTH-stage shift register of {valid, addr, data, lat}; every entry advances one stage each cycle, with no hold.
REQ-022 Stage 1 SHALL load the issue inputs; issue_valid=0 SHALL load a bubble (valid=0).
REQ-023 Latency SHALL be clamped: issue_lat 0 becomes 1; issue_lat >DEPTH becomes DEPTH.
REQ-024 An entry in stage k SHALL be ready when k >= lat.
REQ-025 wb_* SHALL be the stage-DEPTH contents, a pure register output with no combinational path from the issue inputs.
REQ-026 Same-address writeback: when two or more lanes have wb_valid=1 with equal wb_addr, only the highest-index lane SHALL assert wb_valid.
REQ-027 Forwarding SHALL be combinational; per read port, the match is any valid entry in stages 1..DEPTH with addr == rd_addr.
REQ-028 The youngest match (lowest stage) SHALL win; ties within a stage SHALL go to the highest lane.
REQ-029 If the winner is ready: fw_data = winner data and fw_hit = 1.
REQ-030 If the winner is not ready: fw_data = rf_data, fw_hit = 0, and fw_stall = 1.
REQ-031 With no match: fw_data = rf_data and fw_hit = 0.
REQ-032 fw_stall SHALL be the OR over all read ports; it is advisory only and the pipe still advances.
REQ-033 On flush, entries that would occupy stages 1..FLUSH_STAGES after the edge SHALL be loaded invalid; issue inputs that cycle SHALL be discarded.
REQ-034 On flush, older stages SHALL be unaffected.
REQ-035 occupancy SHALL be a registered count updated each edge: +entries entering, −entries leaving stage DEPTH, −entries killed.

Reset
REQ-036 On reset, all stage valid bits and wb_valid SHALL be 0, wb_addr/wb_data 0, and occupancy 0, asynchronously.
REQ-037 Entries in flight at reset assertion SHALL be discarded.
REQ-038 The first issue after reset deassertion SHALL be captured on the next rising edge.

Structure
REQ-039 The shared package SHALL hold the default DATA_W, ADDR_W, and DEPTH values and the packed stage-entry struct {valid, addr, data, lat}.
REQ-040 There SHALL be one sub-module, bypass_lane: a single-lane shift register with flush kill, instantiated LANES times; match and priority logic SHALL live in the top module.

Verification
REQ-041 Issue lane0 addr 5 data 0xAA.. lat 2 at cycle 0; read addr 5 at cycle 1 -> fw_stall=1, fw_data=rf_data; at cycle 2 -> fw_hit=1, fw_data=0xAA...
REQ-042 Lane0 issues addr 9 lat 1 (data A) at cycle 0, then addr 9 lat 1 (data B) at cycle 1; read at cycle 2 -> B (youngest wins).
REQ-043 Both lanes issue addr 3 in the same cycle (lane0 data 1, lane1 data 2) -> wb after DEPTH cycles: lane1 wb_valid=1 data 2, lane0 wb_valid=0; forward returns 2.
REQ-044 Issue addr 4 at cycle 0, flush at cycle 1 with FLUSH_STAGES=1 -> the cycle-0 entry survives to wb at cycle DEPTH; the cycle-1 issue never reaches wb; occupancy drops by the killed count.
REQ-045 Fill both lanes for DEPTH cycles, then assert reset mid-stream -> all wb_valid=0, occupancy=0, fw_hit=0 immediately, with no wb pulse after release.
REQ-046 issue_lat=0 and issue_lat=7 with DEPTH=4 -> ready at stage 1 and stage 4 respectively.
